synth_cfg_bank: RTL

Runtime configuration bank for the synthesizer voices. It replaces the constant ADSR, oscillator and filter settings at the FPGA top with registers loaded over a 3-wire serial link, for NCH independent synth channels. Writes go to shadow registers. A commit frame copies all shadow registers to the active outputs in one clock, so every voice changes its settings at the same time. It also gates each channel's trigger.

---
 rtl/synth_cfg_bank.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/synth_cfg_bank.sv
// Runtime configuration bank for the synth voices: a 3-wire serial link loads
// per-channel shadow registers, and a commit frame moves all of them to the outputs at once.
module synth_cfg_chan #(
    parameter int OSC_W   = 16,
    parameter int DEF_AI  = 64,
    parameter int DEF_DI  = 16,
    parameter int DEF_S   = 128,
    parameter int DEF_RI  = 2,
    parameter int DEF_OSC = 66,
    parameter int DEF_FA  = 17546
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_reg,
    input  logic [15:0]      wr_data,
    input  logic             commit,
    input  logic             trig,
    output logic [7:0]       ai,
    output logic [7:0]       di,
    output logic [7:0]       s,
    output logic [7:0]       ri,
    output logic [OSC_W-1:0] osc,
    output logic [15:0]      fa,
    output logic [15:0]      fb,
    output logic             trig_out
);
    logic [7:0]       sh_ai, sh_di, sh_s, sh_ri;
    logic [OSC_W-1:0] sh_osc;
    logic [15:0]      sh_fa;
    logic             sh_en, sh_st, act_en, act_st;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_ai  <= 8'(DEF_AI);  ai  <= 8'(DEF_AI);
            sh_di  <= 8'(DEF_DI);  di  <= 8'(DEF_DI);
            sh_s   <= 8'(DEF_S);   s   <= 8'(DEF_S);
            sh_ri  <= 8'(DEF_RI);  ri  <= 8'(DEF_RI);
            sh_osc <= OSC_W'(DEF_OSC); osc <= OSC_W'(DEF_OSC);
            sh_fa  <= 16'(DEF_FA); fa  <= 16'(DEF_FA);
            sh_en  <= 1'b1;        act_en <= 1'b1;
            sh_st  <= 1'b0;        act_st <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_reg)
                    4'd0: sh_ai  <= wr_data[7:0];
                    4'd1: sh_di  <= wr_data[7:0];
                    4'd2: sh_s   <= wr_data[7:0];
                    4'd3: sh_ri  <= wr_data[7:0];
                    4'd4: sh_osc <= OSC_W'(wr_data);
                    4'd5: sh_fa  <= wr_data;
                    4'd6: begin sh_en <= wr_data[0]; sh_st <= wr_data[1]; end
                    default: ;
                endcase
            end
            // Writes and commits come from distinct frames, so they never collide.
            if (commit) begin
                ai <= sh_ai; di <= sh_di; s <= sh_s; ri <= sh_ri;
                osc <= sh_osc; fa <= sh_fa;
                act_en <= sh_en; act_st <= sh_st;
            end
        end
    end

    assign fb       = 16'hFFFF - fa;
    assign trig_out = act_en & (trig | act_st);
endmodule

module synth_cfg_bank #(
    parameter int NCH     = 1,
    parameter int OSC_W   = 16,
    parameter int DEF_AI  = 64,
    parameter int DEF_DI  = 16,
    parameter int DEF_S   = 128,
    parameter int DEF_RI  = 2,
    parameter int DEF_OSC = 66,
    parameter int DEF_FA  = 17546
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_sclk,
    input  logic                 cfg_sdi,
    input  logic                 cfg_csn,
    input  logic                 trig,
    output logic [NCH-1:0]       trig_out,
    output logic [8*NCH-1:0]     adsr_ai,
    output logic [8*NCH-1:0]     adsr_di,
    output logic [8*NCH-1:0]     adsr_s,
    output logic [8*NCH-1:0]     adsr_ri,
    output logic [OSC_W*NCH-1:0] osc_count,
    output logic [16*NCH-1:0]    filter_a,
    output logic [16*NCH-1:0]    filter_b,
    output logic                 cfg_commit,
    output logic                 cfg_err
);
    localparam logic [4:0] NCH5 = 5'(NCH);

    // [0],[1] synchronise; [2] is the previous value for edge detection.
    logic [2:0] sclk_q, csn_q;
    logic [1:0] sdi_q;
    always_ff @(posedge clk) begin
        sclk_q <= {sclk_q[1:0], cfg_sclk};
        csn_q  <= {csn_q[1:0], cfg_csn};
        sdi_q  <= {sdi_q[0], cfg_sdi};
    end

    logic sclk_rise, csn_fall, csn_rise;
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign csn_fall  = ~csn_q[1] & csn_q[2];
    assign csn_rise  = csn_q[1] & ~csn_q[2];

    // frame_act only rises on a seen csn fall, so a frame cut by reset is never decoded.
    logic [4:0]  bit_cnt;
    logic [23:0] shreg;
    logic        frame_act;
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_act <= 1'b0;
        end else if (csn_fall) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_act <= 1'b1;
        end else if (csn_rise) begin
            frame_act <= 1'b0;
        end else if (frame_act && sclk_rise) begin
            if (bit_cnt != 5'd25) bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt < 5'd24)  shreg   <= {shreg[22:0], sdi_q[1]};
        end
    end

    logic [3:0]  ch, rix;
    logic [15:0] data;
    logic        wr_en, do_commit, set_err, clr_err;
    assign ch   = shreg[23:20];
    assign rix  = shreg[19:16];
    assign data = shreg[15:0];

    always_comb begin
        wr_en     = 1'b0;
        do_commit = 1'b0;
        set_err   = 1'b0;
        clr_err   = 1'b0;
        if (csn_rise && frame_act) begin
            if (bit_cnt != 5'd24)             set_err   = 1'b1;
            else if (shreg[23:16] == 8'hFF)   begin
                if (data == 16'hA5C3)         do_commit = 1'b1;
                else                          set_err   = 1'b1;
            end
            else if ({1'b0, ch} >= NCH5)      set_err   = 1'b1;
            else if (rix == 4'd15)            clr_err   = 1'b1;
            else if (rix >= 4'd7)             set_err   = 1'b1;
            else                              wr_en     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_commit <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_commit <= do_commit;
            if (set_err)      cfg_err <= 1'b1;
            else if (clr_err) cfg_err <= 1'b0;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        synth_cfg_chan #(
            .OSC_W(OSC_W), .DEF_AI(DEF_AI), .DEF_DI(DEF_DI), .DEF_S(DEF_S),
            .DEF_RI(DEF_RI), .DEF_OSC(DEF_OSC), .DEF_FA(DEF_FA)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en && (ch == 4'(c))),
            .wr_reg   (rix),
            .wr_data  (data),
            .commit   (do_commit),
            .trig     (trig),
            .ai       (adsr_ai[8*c +: 8]),
            .di       (adsr_di[8*c +: 8]),
            .s        (adsr_s[8*c +: 8]),
            .ri       (adsr_ri[8*c +: 8]),
            .osc      (osc_count[OSC_W*c +: OSC_W]),
            .fa       (filter_a[16*c +: 16]),
            .fb       (filter_b[16*c +: 16]),
            .trig_out (trig_out[c])
        );
    end
endmodule
